// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// uart_rx_ctrl: oversampling serial receiver for the uart_ctrl frame
// (start 0, 7 data bits LSB first, fixed 0 "bit7", stop 1). Each good
// character goes to the controller over a 4-phase rcv_req/rcv_ack handshake.
// Framing errors pulse fe for one cycle; overruns set the sticky ovr flag.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rx,
    output logic [6:0] rd,
    output logic       rcv_req,
    input  logic       rcv_ack,
    output logic       fe,
    output logic       ovr
);

    // Counter values at which a sample is taken. The start bit is sampled
    // half a period after detection; later bits are sampled one full period apart.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_BIT7      = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // 2-of-3 majority vote over the sample history.
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Synchroniser and history
    logic             sync_meta_r;
    logic             rx_sync_r;
    logic [2:0]       hist_r;
    logic             sample_s;

    // Receive FSM and datapath
    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_idx_r, bit_idx_s;
    logic [6:0]       shift_r, shift_s;
    logic             bit7_r, bit7_s;
    logic             good_r, good_s;
    logic             fe_r, fe_s;

    // Handshake side
    logic [6:0]       rd_r, rd_s;
    logic             req_r, req_s;
    logic             ovr_r, ovr_s;
    logic             pend_r, pend_s;
    logic [6:0]       pend_data_r, pend_data_s;

    assign sample_s = maj3(hist_r);

    // Two-flop synchroniser for rx, then a 3-deep history for majority voting.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync_meta_r <= 1'b1;
            rx_sync_r   <= 1'b1;
            hist_r      <= 3'b111;
        end else begin
            sync_meta_r <= rx;
            rx_sync_r   <= sync_meta_r;
            hist_r      <= {hist_r[1:0], rx_sync_r};
        end
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 7'd0;
            bit7_r    <= 1'b0;
            good_r    <= 1'b0;
            fe_r      <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            bit7_r    <= bit7_s;
            good_r    <= good_s;
            fe_r      <= fe_s;
        end
    end

    // Next-state logic: bit timing, data shifting and frame validation.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        bit7_s    = bit7_r;
        good_s    = 1'b0;
        fe_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (!rx_sync_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = '0;
                    if (sample_s) begin
                        state_s = ST_IDLE;          // glitch, not a start bit
                    end else begin
                        state_s   = ST_DATA;
                        bit_idx_s = 3'd0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s   = '0;
                    shift_s = {sample_s, shift_r[6:1]};
                    if (bit_idx_r == 3'd6) begin
                        state_s = ST_BIT7;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_BIT7: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s   = '0;
                    bit7_s  = sample_s;
                    state_s = ST_STOP;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt_r == FULL_LAST) begin
                    cnt_s = '0;
                    if (sample_s && !bit7_r) begin
                        good_s = 1'b1;
                    end else begin
                        fe_s = 1'b1;
                    end
                    // A low stop bit may be a break: wait for the line to recover.
                    if (!sample_s) begin
                        state_s = ST_WAIT_IDLE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                cnt_s = '0;
                if (rx_sync_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Handshake: deliver, hold pending while ack is high, flag overruns.
    always_comb begin
        rd_s        = rd_r;
        req_s       = req_r;
        ovr_s       = ovr_r;
        pend_s      = pend_r;
        pend_data_s = pend_data_r;

        if (pend_r && !rcv_ack && !req_r) begin
            rd_s  = pend_data_r;
            req_s = 1'b1;
        end else if (good_r && !req_r && !pend_r && !rcv_ack) begin
            rd_s  = shift_r;
            req_s = 1'b1;
        end else if (rcv_ack && req_r) begin
            req_s = 1'b0;
        end else begin
            req_s = req_r;
        end

        if (good_r && !req_r && !pend_r && rcv_ack) begin
            pend_s      = 1'b1;
            pend_data_s = shift_r;
        end else if (pend_r && !rcv_ack && !req_r) begin
            pend_s = 1'b0;
        end else begin
            pend_s = pend_r;
        end

        // A new overrun wins over a clearing acknowledge in the same cycle.
        if (good_r && (req_r || pend_r)) begin
            ovr_s = 1'b1;
        end else if (rcv_ack && ovr_r) begin
            ovr_s = 1'b0;
        end else begin
            ovr_s = ovr_r;
        end
    end

    // Handshake registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_r        <= 7'd0;
            req_r       <= 1'b0;
            ovr_r       <= 1'b0;
            pend_r      <= 1'b0;
            pend_data_r <= 7'd0;
        end else begin
            rd_r        <= rd_s;
            req_r       <= req_s;
            ovr_r       <= ovr_s;
            pend_r      <= pend_s;
            pend_data_r <= pend_data_s;
        end
    end

    assign rd      = rd_r;
    assign rcv_req = req_r;
    assign fe      = fe_r;
    assign ovr     = ovr_r;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the team's uart_ctrl transmitter.
- Frame format is identical to the one uart_ctrl drives:
  - idle 1, start bit 0
  - 7 data bits, LSB first
  - one fixed 0 bit ("bit7")
  - stop bit 1
- Oversamples the line, validates the frame and hands each 7-bit character to a controller over a 4-phase req/ack handshake.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit period; must be even and ≥ 8.
- CNT_W, 8, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk.
- rd  output  7  received character; valid while rcv_req=1.
- rcv_req  output  1  character available.
- rcv_ack  input  1  controller acknowledge.
- fe  output  1  framing error, one-cycle pulse.
- ovr  output  1  overrun flag, sticky.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, counters cleared.
  - Synchroniser flops and 3-bit sample history all set to 1.
  - rd=0, rcv_req=0, fe=0, ovr=0.
- Synchroniser: rx passes through 2 flops to give rx_s. The FSM sees only rx_s.
- Sample history: h[2:0] shifts rx_s in every cycle. The sampled bit value is maj(h) (2-of-3 majority).
- Sample timing:
  - Let D be the edge at which the FSM in IDLE first sees rx_s=0.
  - Bit n is sampled at edge D + CLKS_PER_BIT/2 + n*CLKS_PER_BIT.
  - n=0 start, 1..7 data[0..6], 8 bit7, 9 stop.
- FSM states: IDLE, START, DATA, BIT7, STOP, WAIT_IDLE.
  - IDLE: rx_s=0 → START, cnt=0.
  - START:
    - At the start sample, maj=1 → IDLE (glitch rejected, no flags).
    - maj=0 → DATA, cnt restarts, bit index=0.
  - DATA: at each sample, shift maj into the shift register, LSB first. After data[6] → BIT7.
  - BIT7: sample value recorded; → STOP.
  - STOP, at the stop sample:
    - Stop=1 and bit7=0 → frame good.
    - Otherwise → fe=1 for exactly 1 cycle; character discarded.
    - If stop=0 → WAIT_IDLE; else → IDLE.
  - WAIT_IDLE: remain until rx_s=1 (break handling) → IDLE.
- Good-frame delivery, on the edge after the stop sample:
  - If rcv_req=0: rd ← character, rcv_req ← 1. Latency: rcv_req rises at D + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1; for 16 that is D+153.
  - If rcv_req=1: rd is unchanged, the new character is dropped, ovr ← 1.
- Handshake (4-phase):
  - rcv_req holds, with rd stable, until rcv_ack=1 is sampled; rcv_req then falls on the next edge.
  - No new rcv_req rises while rcv_ack=1. A frame completing during that time is held pending and delivered on the edge after rcv_ack falls.
  - Only one frame is pending. A second completion overwrites nothing and sets ovr.
- ovr clears on the edge at which rcv_ack=1 is sampled while ovr=1.
- rcv_ack=1 while rcv_req=0 with nothing pending is ignored.
- The receiver keeps hunting and receiving regardless of handshake state; the FSM never stalls.
- Reset mid-frame: all state is abandoned immediately. After release, the block resumes in IDLE; a partially received line is treated as a fresh start, and a garbage frame is acceptable.

Test Plan:
- Clean frame, CLKS_PER_BIT=16, char 7'h41 → rcv_req at D+153, rd=7'h41, fe=0, ovr=0. Hold rcv_ack → rcv_req falls 1 cycle later.
- 3-cycle low glitch on idle line → stays IDLE, no rcv_req, no fe.
- 1-cycle spike of the wrong polarity at the mid-sample of data[3], char 7'h55 → majority still gives rd=7'h55.
- Stop bit driven 0, line held low 40 bit-times then released; then a good frame 7'h12 → fe pulses 1 cycle, FSM in WAIT_IDLE until line high, then rd=7'h12 delivered.
- Two back-to-back frames 7'h01, 7'h02 with rcv_ack held low → rd stays 7'h01, ovr=1 after the second stop sample; ack → ovr=0, rcv_req falls.
- clr asserted at data[4] of a frame → all outputs 0 immediately. Next clean frame 7'h7F after release → received correctly.
